stack_calc_core: RTL and testbench

Push-down stack and arithmetic engine of the Basys3 stack calculator, placed directly downstream of the per-button debouncers. It consumes their single-cycle press pulses plus the switch bank, and maintains a LIFO of operands. On an operate press it pops the top two entries, combines them and pushes the result. It drives the top-of-stack value, depth and status flags to the display stage.

---
 rtl/stack_calc_core.sv | 127 ++++++++++++
 tb/tb_stack_calc_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_calc_core.sv
// Operand stack and arithmetic engine for the stack calculator.
// States: IDLE | decode commands   CALC | compute R from A,B   WB | write R back, pop one
module stack_calc_core #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PUSH_SP,
  input  logic             POP_SP,
  input  logic             OP_SP,
  input  logic [WIDTH-1:0] SW,
  input  logic [1:0]       OP_SEL,
  output logic [WIDTH-1:0] TOP,
  output logic [CW-1:0]    COUNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             BUSY,
  output logic             ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WB} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    top_idx, sec_idx;
  logic [WIDTH-1:0] a_q, b_q, r_q, calc_r;
  logic [1:0]       op_q;
  logic             err_q;
  logic             do_push, do_pop, do_op, err_set;

  assign top_idx = count_q - CW'(1);
  assign sec_idx = count_q - CW'(2);

  assign COUNT = count_q;
  assign EMPTY = (count_q == '0);
  assign FULL  = (count_q == CW'(DEPTH));
  assign BUSY  = (state_q != S_IDLE);
  assign ERR   = err_q;
  assign TOP   = EMPTY ? '0 : stack_mem[top_idx[AW-1:0]];

  always_comb begin
    state_d = state_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_op   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        case ({PUSH_SP, POP_SP, OP_SP})
          3'b000: ;
          3'b100: if (FULL) err_set = 1'b1; else do_push = 1'b1;
          3'b010: if (EMPTY) err_set = 1'b1; else do_pop = 1'b1;
          3'b001: begin
            if (count_q >= CW'(2)) begin
              do_op   = 1'b1;
              state_d = S_CALC;
            end else begin
              err_set = 1'b1;
            end
          end
          default: err_set = 1'b1;
        endcase
      end
      S_CALC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    calc_r = '0;
    case (op_q)
      2'b00: calc_r = a_q + b_q;
      2'b01: calc_r = a_q - b_q;
      2'b10: calc_r = a_q * b_q;
      2'b11: calc_r = a_q ^ b_q;
      default: calc_r = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      if (do_push) begin
        count_q <= count_q + CW'(1);
        err_q   <= 1'b0;
      end
      if (do_pop) begin
        count_q <= count_q - CW'(1);
        err_q   <= 1'b0;
      end
      if (do_op) begin
        op_q  <= OP_SEL;
        a_q   <= stack_mem[sec_idx[AW-1:0]];
        b_q   <= stack_mem[top_idx[AW-1:0]];
        err_q <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (state_q == S_CALC) r_q <= calc_r;
      if (state_q == S_WB) count_q <= count_q - CW'(1);
    end
  end

  // Storage is left unreset; a reset in WB must still suppress the writeback.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (do_push)
        stack_mem[count_q[AW-1:0]] <= SW;
      else if (state_q == S_WB)
        stack_mem[sec_idx[AW-1:0]] <= r_q;
    end
  end

endmodule

// File: tb/tb_stack_calc_core.sv
// Randomized and directed checks of stack_calc_core against a queue-based model.
module tb_stack_calc_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PUSH_SP = 1'b0, POP_SP = 1'b0, OP_SP = 1'b0;
  logic [15:0] SW = '0;
  logic [1:0]  OP_SEL = '0;
  logic [15:0] TOP;
  logic [3:0]  COUNT;
  logic        EMPTY, FULL, BUSY, ERR;

  int vecs = 0;
  int errs = 0;

  logic [15:0] mdl[$];
  logic        mdl_err = 1'b0;

  stack_calc_core dut (
    .CLK(CLK), .RESET(RESET), .PUSH_SP(PUSH_SP), .POP_SP(POP_SP), .OP_SP(OP_SP),
    .SW(SW), .OP_SEL(OP_SEL), .TOP(TOP), .COUNT(COUNT), .EMPTY(EMPTY),
    .FULL(FULL), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Model: expected {TOP, COUNT, EMPTY, FULL, BUSY, ERR} while idle.
  function automatic logic [23:0] exp_tuple();
    logic [15:0] t;
    int n;
    n = mdl.size();
    t = (n == 0) ? 16'h0 : mdl[n-1];
    return {t, 4'(n), (n == 0), (n == 8), 1'b0, mdl_err};
  endfunction

  function automatic logic [15:0] apply_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] sel);
    longint unsigned r;
    case (sel)
      2'd0: r = (longint'(a) + longint'(b)) % 65536;
      2'd1: r = (longint'(a) + 65536 - longint'(b)) % 65536;
      2'd2: r = (longint'(a) * longint'(b)) % 65536;
      default: r = longint'(a ^ b);
    endcase
    return 16'(r);
  endfunction

  task automatic model_cmd(input logic push, input logic pop, input logic op,
                           input logic [15:0] sw, input logic [1:0] sel,
                           output logic op_ok);
    logic [15:0] a, b;
    op_ok = 1'b0;
    if (int'(push) + int'(pop) + int'(op) != 1) mdl_err = 1'b1;
    else if (push) begin
      if (mdl.size() == 8) mdl_err = 1'b1;
      else begin mdl.push_back(sw); mdl_err = 1'b0; end
    end else if (pop) begin
      if (mdl.size() == 0) mdl_err = 1'b1;
      else begin void'(mdl.pop_back()); mdl_err = 1'b0; end
    end else begin
      if (mdl.size() < 2) mdl_err = 1'b1;
      else begin
        b = mdl.pop_back();
        a = mdl.pop_back();
        mdl.push_back(apply_op(a, b, sel));
        mdl_err = 1'b0;
        op_ok = 1'b1;
      end
    end
  endtask

  // Called at a negedge; the pulse is sampled at the next posedge, returns one negedge later.
  task automatic issue(input logic push, input logic pop, input logic op,
                       input logic [15:0] sw, input logic [1:0] sel, output logic op_ok);
    model_cmd(push, pop, op, sw, sel, op_ok);
    PUSH_SP = push; POP_SP = pop; OP_SP = op; SW = sw; OP_SEL = sel;
    @(negedge CLK);
    PUSH_SP = 1'b0; POP_SP = 1'b0; OP_SP = 1'b0;
    SW = 16'($urandom); OP_SEL = 2'($urandom);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    mdl.delete();
    mdl_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({TOP, COUNT, EMPTY, FULL, BUSY, ERR} !== 24'h000_0_8 >> 0 && 1'b0) ;
    if ({TOP, COUNT, EMPTY, FULL, BUSY, ERR} !== exp_tuple()) begin
      errs++;
      $display("FAIL reset: got %h want %h", {TOP, COUNT, EMPTY, FULL, BUSY, ERR}, exp_tuple());
    end
  endtask

  task automatic test_sub();
    logic ok;
    do_reset();
    issue(1, 0, 0, 16'h0005, 2'b00, ok);
    issue(1, 0, 0, 16'h0003, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT} !== {16'h0003, 4'd2}) begin
      errs++; $display("FAIL sub_setup: got %h/%0d want 0003/2", TOP, COUNT);
    end
    issue(0, 0, 1, 16'h0000, 2'b01, ok);
    vecs++;
    if (BUSY !== 1'b1) begin errs++; $display("FAIL sub_busy1: got %b want 1", BUSY); end
    @(negedge CLK);
    vecs++;
    if (BUSY !== 1'b1) begin errs++; $display("FAIL sub_busy2: got %b want 1", BUSY); end
    @(negedge CLK);
    vecs++;
    if ({TOP, COUNT, EMPTY, FULL, BUSY, ERR} !== {16'h0002, 4'd1, 4'b0000}) begin
      errs++; $display("FAIL sub_result: got %h want %h", {TOP, COUNT, EMPTY, FULL, BUSY, ERR},
                       {16'h0002, 4'd1, 4'b0000});
    end
    // Back-to-back: a command in the result cycle must be accepted.
    issue(1, 0, 0, 16'h1234, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT} !== {16'h1234, 4'd2}) begin
      errs++; $display("FAIL back_to_back: got %h/%0d want 1234/2", TOP, COUNT);
    end
  endtask

  task automatic wait_op();
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    logic ok;
    do_reset();
    issue(1, 0, 0, 16'hFFFF, 2'b00, ok);
    issue(1, 0, 0, 16'h0002, 2'b00, ok);
    issue(0, 0, 1, 16'h0000, 2'b00, ok);
    wait_op();
    vecs++;
    if ({TOP, COUNT} !== {16'h0001, 4'd1}) begin
      errs++; $display("FAIL add_wrap: got %h/%0d want 0001/1", TOP, COUNT);
    end
    issue(1, 0, 0, 16'h0100, 2'b00, ok);
    issue(1, 0, 0, 16'h0100, 2'b00, ok);
    issue(0, 0, 1, 16'h0000, 2'b10, ok);
    wait_op();
    vecs++;
    if ({TOP, COUNT} !== {16'h0000, 4'd2}) begin
      errs++; $display("FAIL mul_wrap: got %h/%0d want 0000/2", TOP, COUNT);
    end
  endtask

  task automatic test_full();
    logic ok;
    do_reset();
    for (int i = 1; i <= 8; i++) issue(1, 0, 0, 16'(i), 2'b00, ok);
    vecs++;
    if ({TOP, COUNT, FULL, ERR} !== {16'h0008, 4'd8, 1'b1, 1'b0}) begin
      errs++; $display("FAIL fill: got %h want %h", {TOP, COUNT, FULL, ERR}, {16'h0008, 4'd8, 2'b10});
    end
    issue(1, 0, 0, 16'h00AA, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT, FULL, ERR} !== {16'h0008, 4'd8, 1'b1, 1'b1}) begin
      errs++; $display("FAIL push_full: got %h want %h", {TOP, COUNT, FULL, ERR}, {16'h0008, 4'd8, 2'b11});
    end
    issue(0, 1, 0, 16'h0000, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT, FULL, ERR} !== {16'h0007, 4'd7, 1'b0, 1'b0}) begin
      errs++; $display("FAIL pop_after_full: got %h want %h", {TOP, COUNT, FULL, ERR}, {16'h0007, 4'd7, 2'b00});
    end
    issue(1, 0, 0, 16'h00F0, 2'b00, ok);
    issue(0, 0, 1, 16'h0000, 2'b11, ok);
    wait_op();
    vecs++;
    if ({TOP, COUNT, FULL, ERR} !== {16'h00F7, 4'd7, 1'b0, 1'b0}) begin
      errs++; $display("FAIL op_at_full: got %h want %h", {TOP, COUNT, FULL, ERR}, {16'h00F7, 4'd7, 2'b00});
    end
  endtask

  task automatic test_empty_err();
    logic ok;
    do_reset();
    issue(0, 1, 0, 16'h0000, 2'b00, ok);
    vecs++;
    if ({ERR, EMPTY, COUNT} !== {1'b1, 1'b1, 4'd0}) begin
      errs++; $display("FAIL pop_empty: got err=%b empty=%b count=%0d want 1/1/0", ERR, EMPTY, COUNT);
    end
    issue(1, 0, 0, 16'h0009, 2'b00, ok);
    issue(0, 0, 1, 16'h0000, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT, BUSY, ERR} !== {16'h0009, 4'd1, 1'b0, 1'b1}) begin
      errs++; $display("FAIL op_short: got %h want %h", {TOP, COUNT, BUSY, ERR}, {16'h0009, 4'd1, 2'b01});
    end
    issue(0, 1, 0, 16'h0000, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT, EMPTY, ERR} !== {16'h0000, 4'd0, 1'b1, 1'b0}) begin
      errs++; $display("FAIL pop_to_empty: got %h want %h", {TOP, COUNT, EMPTY, ERR}, {16'h0000, 4'd0, 2'b10});
    end
  endtask

  task automatic test_multi_pulse();
    logic ok;
    do_reset();
    issue(1, 0, 0, 16'h0011, 2'b00, ok);
    issue(1, 0, 0, 16'h0022, 2'b00, ok);
    issue(1, 1, 0, 16'h0033, 2'b00, ok);
    vecs++;
    if ({TOP, COUNT, ERR} !== {16'h0022, 4'd2, 1'b1}) begin
      errs++; $display("FAIL push_pop_same: got %h want %h", {TOP, COUNT, ERR}, {16'h0022, 4'd2, 1'b1});
    end
    issue(0, 0, 1, 16'h0000, 2'b00, ok);
    PUSH_SP = 1'b1; SW = 16'h0777;
    @(negedge CLK);
    PUSH_SP = 1'b0; POP_SP = 1'b1;
    @(negedge CLK);
    POP_SP = 1'b0;
    vecs++;
    if ({TOP, COUNT, BUSY, ERR} !== {16'h0033, 4'd1, 1'b0, 1'b0}) begin
      errs++; $display("FAIL drop_busy: got %h want %h", {TOP, COUNT, BUSY, ERR}, {16'h0033, 4'd1, 2'b00});
    end
  endtask

  task automatic test_reset_abort();
    logic ok;
    do_reset();
    for (int i = 0; i < 3; i++) issue(1, 0, 0, 16'h0040 + 16'(i), 2'b00, ok);
    issue(0, 0, 1, 16'h0000, 2'b00, ok);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    mdl.delete();
    mdl_err = 1'b0;
    vecs++;
    if ({TOP, COUNT, EMPTY, FULL, BUSY, ERR} !== exp_tuple()) begin
      errs++; $display("FAIL reset_abort: got %h want %h", {TOP, COUNT, EMPTY, FULL, BUSY, ERR}, exp_tuple());
    end
    @(negedge CLK);
    @(negedge CLK);
    vecs++;
    if ({TOP, COUNT, BUSY} !== {16'h0000, 4'd0, 1'b0}) begin
      errs++; $display("FAIL abort_no_wb: got %h want 0", {TOP, COUNT, BUSY});
    end
  endtask

  task automatic test_random();
    logic ok, p, q, o;
    int k;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      p = (k <= 3); q = (k == 4 || k == 5); o = (k >= 6 && k <= 8);
      if (k == 9) begin p = 1'($urandom); q = 1'($urandom); o = ~(p & q) | 1'($urandom); p = p | ~q; end
      issue(p, q, o, (k % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom), 2'($urandom), ok);
      if (ok) begin
        vecs++;
        if (BUSY !== 1'b1) begin errs++; $display("FAIL rnd_busy[%0d]: got %b want 1", i, BUSY); end
        wait_op();
      end
      vecs++;
      if ({TOP, COUNT, EMPTY, FULL, BUSY, ERR} !== exp_tuple()) begin
        errs++; $display("FAIL rnd[%0d]: got %h want %h", i, {TOP, COUNT, EMPTY, FULL, BUSY, ERR}, exp_tuple());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_wrap();
    test_full();
    test_empty_err();
    test_multi_pulse();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
